aes128_core: RTL and testbench

Iterative AES-128 block cipher core (FIPS-197) that encrypts or decrypts one 128-bit block per request. It runs one round per clock and computes round keys on the fly, so no key RAM is needed. It is the DUT behind the `aes_if` agent and sits between a requesting master, which drives `start`, `din`, `key_in` and `cipher`, and a consumer that samples `dout` on `finish`.

---
 rtl/aes_pkg.sv | 130 +++++++++++++
 rtl/aes128_sbox.sv | 23 ++
 rtl/aes128_core.sv | 154 +++++++++++++++
 tb/tb_aes128_core.sv | 119 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 tables and round/key-step helpers shared by the core and its S-box.
// Inverse tables and functions exist only when AES128_DECRYPT_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} aes_state_e;

  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  // Byte b lives at SBOX[8*(255-b) +: 8]; rows are listed from entry 0x00 upward.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    if (i > 4'd9) return 8'h00;
    return RCON[8*(9-int'(i)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state sits at s[127-8*i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [31:0] sw,
                                           input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sw ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

`ifdef AES128_DECRYPT_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  // GF(2^8) multiply by a 4-bit constant built from a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h0) ^ (m[1] ? x2 : 8'h0) ^ (m[2] ? x4 : 8'h0) ^ (m[3] ? x8 : 8'h0);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Undo key_fwd: w3 is recovered first, so sw must be SubWord(RotWord(w3'^w2')).
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [31:0] sw,
                                           input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sw ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
`endif

endpackage

// File: rtl/aes128_sbox.sv
// 16-byte parallel S-box; inv_i selects the inverse table when AES128_DECRYPT_EN is defined.
module aes128_sbox
  import aes_pkg::*;
(
  input  logic [127:0] in_i,
  input  logic         inv_i,
  output logic [127:0] out_o
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
`ifdef AES128_DECRYPT_EN
    assign out_o[8*i +: 8] = inv_i ? sbox_inv(in_i[8*i +: 8]) : sbox_fwd(in_i[8*i +: 8]);
`else
    assign out_o[8*i +: 8] = sbox_fwd(in_i[8*i +: 8]);
`endif
  end

`ifndef AES128_DECRYPT_EN
  logic unused_inv;
  assign unused_inv = inv_i;
`endif

endmodule

// File: rtl/aes128_core.sv
// Iterative AES-128 core: one round per clock, round keys derived on the fly.
// AES128_DECRYPT_EN adds decryption (forward key expansion, then inverse rounds).
module aes128_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] key_in,
  input  logic         cipher,
  output logic [127:0] dout,
  output logic         finish
);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, dout_q, dout_d;
  logic [3:0]   round_q, round_d;
  logic         finish_q, finish_d;

  logic         enc, last;
  logic [3:0]   rc_idx;
  logic [31:0]  kw, sw;
  logic [127:0] sb_in, sb_out, rk_fwd, enc_res;

  assign last = (round_q == 4'd10);

`ifdef AES128_DECRYPT_EN
  logic         enc_q, enc_d;
  logic [127:0] rk_inv, dec_ark, dec_res;

  assign enc   = enc_q;
  assign sb_in = enc ? st_q : inv_shift_rows(st_q);
  // Expansion walks forward from w3; the inverse step needs the recovered old w3.
  assign kw    = (enc || fsm_q == S_KEYEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);

  always_comb begin
    rc_idx = round_q - 4'd1;
    if (fsm_q == S_KEYEXP) rc_idx = round_q;
    else if (!enc)         rc_idx = 4'd10 - round_q;
  end

  assign rk_inv  = key_inv(rk_q, sw, rcon(rc_idx));
  assign dec_ark = sb_out ^ rk_inv;
  assign dec_res = last ? dec_ark : inv_mix_columns(dec_ark);
`else
  logic unused_cipher;
  assign unused_cipher = cipher;
  assign enc    = 1'b1;
  assign sb_in  = st_q;
  assign kw     = rk_q[31:0];
  assign rc_idx = round_q - 4'd1;
`endif

  aes128_sbox u_sbox (
    .in_i  (sb_in),
    .inv_i (~enc),
    .out_o (sb_out)
  );

  // Key word path: RotWord then four independent forward lookups.
  assign sw = {sbox_fwd(kw[23:16]), sbox_fwd(kw[15:8]), sbox_fwd(kw[7:0]), sbox_fwd(kw[31:24])};

  assign rk_fwd  = key_fwd(rk_q, sw, rcon(rc_idx));
  assign enc_res = (last ? shift_rows(sb_out) : mix_columns(shift_rows(sb_out))) ^ rk_fwd;

  always_comb begin
    fsm_d    = fsm_q;
    st_d     = st_q;
    rk_d     = rk_q;
    round_d  = round_q;
    dout_d   = dout_q;
    finish_d = 1'b0;
`ifdef AES128_DECRYPT_EN
    enc_d    = enc_q;
`endif
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (fsm_q == S_DONE) fsm_d = S_IDLE;
        if (start) begin
          rk_d = key_in;
`ifdef AES128_DECRYPT_EN
          enc_d = cipher;
          if (!cipher) begin
            st_d    = din;
            round_d = 4'd0;
            fsm_d   = S_KEYEXP;
          end else
`endif
          begin
            st_d    = din ^ key_in;
            round_d = 4'd1;
            fsm_d   = S_ROUND;
          end
        end
      end
`ifdef AES128_DECRYPT_EN
      S_KEYEXP: begin
        rk_d    = rk_fwd;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) begin
          st_d    = st_q ^ rk_fwd;
          round_d = 4'd1;
          fsm_d   = S_ROUND;
        end
      end
`endif
      S_ROUND: begin
`ifdef AES128_DECRYPT_EN
        st_d = enc ? enc_res : dec_res;
        rk_d = enc ? rk_fwd : rk_inv;
`else
        st_d = enc_res;
        rk_d = rk_fwd;
`endif
        round_d = round_q + 4'd1;
        if (last) begin
          dout_d   = st_d;
          finish_d = 1'b1;
          fsm_d    = S_DONE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      fsm_q    <= S_IDLE;
      st_q     <= '0;
      rk_q     <= '0;
      round_q  <= '0;
      dout_q   <= '0;
      finish_q <= 1'b0;
`ifdef AES128_DECRYPT_EN
      enc_q    <= 1'b0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      st_q     <= st_d;
      rk_q     <= rk_d;
      round_q  <= round_d;
      dout_q   <= dout_d;
      finish_q <= finish_d;
`ifdef AES128_DECRYPT_EN
      enc_q    <= enc_d;
`endif
    end
  end

  assign dout   = dout_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_aes128_core.sv
// Directed FIPS-197 vectors against aes128_core: latency, capture, abort, back-to-back.
module tb_aes128_core;

  logic         clk, arst, start, cipher, finish;
  logic [127:0] din, key_in, dout;
  int           n_chk, n_pass;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_core dut (
    .clk    (clk),
    .arst   (arst),
    .start  (start),
    .din    (din),
    .key_in (key_in),
    .cipher (cipher),
    .dout   (dout),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge. Inputs are scrambled right after capture; poke>0 re-pulses
  // start mid-operation; tail watches for stray finish pulses afterwards.
  task automatic do_op(input string tag, input logic [127:0] k, input logic [127:0] d,
                       input logic c, input logic [127:0] exp, input int exp_lat,
                       input int poke, input bit tail);
    int lat, extra;
    bit got, stable;
    logic [127:0] old;
    start = 1'b1; din = d; key_in = k; cipher = c;
    @(posedge clk); #1;
    start = 1'b0; din = ~d; key_in = ~k; cipher = ~c;
    old = dout; lat = 0; got = 1'b0; stable = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
      start = (lat == poke);
      if (finish) got = 1'b1;
      else if (dout !== old) stable = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_stable"}, 128'(stable), 128'd1);
    if (tail) begin
      extra = 0;
      repeat (15) begin
        @(negedge clk);
        if (finish) extra++;
      end
      chk({tag, "_extra_fin"}, 128'(extra), 128'd0);
      chk({tag, "_hold"}, dout, exp);
    end
  endtask

  initial begin
    int fins;
    n_chk = 0; n_pass = 0;
    arst = 1'b0; start = 1'b0; cipher = 1'b1; din = '0; key_in = '0;
    #2;
    chk("rst_dout", dout, '0);
    chk("rst_fin", 128'(finish), 128'd0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);

    // First op ends in DONE; the second starts in that very cycle.
    do_op("enc1", K1, P1, 1'b1, C1, 10, 0, 1'b0);
    do_op("b2b", K2, P2, 1'b1, C2, 10, 0, 1'b1);

`ifdef AES128_DECRYPT_EN
    do_op("dec1", K1, C1, 1'b0, P1, 20, 0, 1'b1);
`else
    do_op("cipher_ign", K1, P1, 1'b0, C1, 10, 0, 1'b1);
`endif

    do_op("zero_poke", '0, '0, 1'b1, CZ, 10, 3, 1'b1);

    // Abort mid-operation with reset.
    start = 1'b1; din = P2; key_in = K2; cipher = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("abort_dout", dout, '0);
    chk("abort_fin", 128'(finish), 128'd0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    fins = 0;
    repeat (25) begin
      @(negedge clk);
      if (finish) fins++;
    end
    chk("abort_nofin", 128'(fins), 128'd0);
    chk("abort_dout_hold", dout, '0);

    do_op("fresh", K1, P1, 1'b1, C1, 10, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
